// File: rtl/calc2_pkg.sv
// rtl/calc2_pkg.sv - shared types, sizes and ALU functions for the Calc2 compute block
package calc2_pkg;
    localparam int NUM_PORTS = 4;
    localparam int DATA_W    = 32;
    localparam int TAG_W     = 2;
    localparam int NUM_TAGS  = 1 << TAG_W;
    localparam int SHAMT_W   = $clog2(DATA_W);

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_SHL = 4'd5,
        CMD_SHR = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef struct packed {
        logic              valid;
        logic [3:0]        cmd;
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
    } tag_entry_t;

    typedef struct packed {
        resp_e             resp;
        logic [DATA_W-1:0] data;
    } alu_result_t;

    function automatic logic is_shift(input logic [3:0] cmd);
        return (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

    function automatic logic [TAG_W-1:0] first_set(input logic [NUM_TAGS-1:0] vec);
        logic [TAG_W-1:0] idx;
        idx = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--) begin
            if (vec[t]) idx = TAG_W'(t);
        end
        return idx;
    endfunction

    // Anything that is not add or sub lands here too and reports an error.
    function automatic alu_result_t alu_addsub(input logic [3:0]        cmd,
                                               input logic [DATA_W-1:0] op1,
                                               input logic [DATA_W-1:0] op2);
        alu_result_t       r;
        logic [DATA_W:0]   sum;
        r.resp = RESP_ERR;
        r.data = '0;
        sum    = {1'b0, op1} + {1'b0, op2};
        if (cmd == CMD_ADD) begin
            if (!sum[DATA_W]) begin
                r.resp = RESP_OK;
                r.data = sum[DATA_W-1:0];
            end
        end else if (cmd == CMD_SUB) begin
            if (op2 <= op1) begin
                r.resp = RESP_OK;
                r.data = op1 - op2;
            end
        end
        return r;
    endfunction

    function automatic alu_result_t alu_shift(input logic [3:0]        cmd,
                                              input logic [DATA_W-1:0] op1,
                                              input logic [DATA_W-1:0] op2);
        alu_result_t r;
        r.resp = RESP_OK;
        if (cmd == CMD_SHL) r.data = op1 << op2[SHAMT_W-1:0];
        else                r.data = op1 >> op2[SHAMT_W-1:0];
        return r;
    endfunction
endpackage

// File: rtl/calc2_port_ctrl.sv
// rtl/calc2_port_ctrl.sv - per-port two-cycle command capture and tag table
module calc2_port_ctrl
    import calc2_pkg::*;
(
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        cmd_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              add_grant,
    input  logic              shift_grant,
    output logic              add_ready,
    output logic              shift_ready,
    output logic [TAG_W-1:0]  add_tag,
    output tag_entry_t        add_entry,
    output logic [TAG_W-1:0]  shift_tag,
    output tag_entry_t        shift_entry,
    output logic              wr_en,
    output logic [TAG_W-1:0]  wr_tag
);
    typedef enum logic {ST_IDLE, ST_OP2} cap_state_e;

    cap_state_e           state;
    cap_state_e           state_nxt;
    logic                 cap_en;
    logic [3:0]           cap_cmd;
    logic [TAG_W-1:0]     cap_tag;
    logic [DATA_W-1:0]    cap_op1;
    tag_entry_t           table_q [NUM_TAGS];
    logic [NUM_TAGS-1:0]  add_vec;
    logic [NUM_TAGS-1:0]  shift_vec;

    always_ff @(posedge c_clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (cmd_in != 4'd0) state_nxt = ST_OP2;
            ST_OP2:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The cmd lines are only looked at in IDLE, so the operand-2 cycle ignores them.
    always_comb begin
        cap_en = (state == ST_IDLE) && (cmd_in != 4'd0);
        wr_en  = (state == ST_OP2);
        wr_tag = cap_tag;
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            cap_cmd <= '0;
            cap_tag <= '0;
            cap_op1 <= '0;
        end else if (cap_en) begin
            cap_cmd <= cmd_in;
            cap_tag <= tag_in;
            cap_op1 <= data_in;
        end
    end

    // A write into the same slot as a same-edge dispatch must win, so it comes last.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int t = 0; t < NUM_TAGS; t++) table_q[t] <= '0;
        end else begin
            if (add_grant)   table_q[add_tag].valid   <= 1'b0;
            if (shift_grant) table_q[shift_tag].valid <= 1'b0;
            if (wr_en) begin
                table_q[wr_tag] <= '{valid: 1'b1, cmd: cap_cmd, op1: cap_op1, op2: data_in};
            end
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TAGS; t++) begin
            add_vec[t]   = table_q[t].valid && !is_shift(table_q[t].cmd);
            shift_vec[t] = table_q[t].valid &&  is_shift(table_q[t].cmd);
        end
    end

    assign add_ready   = |add_vec;
    assign shift_ready = |shift_vec;
    assign add_tag     = first_set(add_vec);
    assign shift_tag   = first_set(shift_vec);
    assign add_entry   = table_q[add_tag];
    assign shift_entry = table_q[shift_tag];
endmodule

// File: rtl/calc2_unit.sv
// rtl/calc2_unit.sv - four-port tagged calculator top: arbiters, ALUs, outputs (checks under CALC2_SVA_EN)
module calc2_unit
    import calc2_pkg::*;
(
    input  logic              c_clk,
    input  logic              reset,
    input  logic              a_clk,
    input  logic              b_clk,
    input  logic              scan_in,
    output logic              scan_out,
    input  logic [3:0]        req1_cmd_in,
    input  logic [DATA_W-1:0] req1_data_in,
    input  logic [TAG_W-1:0]  req1_tag_in,
    input  logic [3:0]        req2_cmd_in,
    input  logic [DATA_W-1:0] req2_data_in,
    input  logic [TAG_W-1:0]  req2_tag_in,
    input  logic [3:0]        req3_cmd_in,
    input  logic [DATA_W-1:0] req3_data_in,
    input  logic [TAG_W-1:0]  req3_tag_in,
    input  logic [3:0]        req4_cmd_in,
    input  logic [DATA_W-1:0] req4_data_in,
    input  logic [TAG_W-1:0]  req4_tag_in,
    output logic [1:0]        out_resp1,
    output logic [DATA_W-1:0] out_data1,
    output logic [TAG_W-1:0]  out_tag1,
    output logic [1:0]        out_resp2,
    output logic [DATA_W-1:0] out_data2,
    output logic [TAG_W-1:0]  out_tag2,
    output logic [1:0]        out_resp3,
    output logic [DATA_W-1:0] out_data3,
    output logic [TAG_W-1:0]  out_tag3,
    output logic [1:0]        out_resp4,
    output logic [DATA_W-1:0] out_data4,
    output logic [TAG_W-1:0]  out_tag4
);
    localparam int PORT_W = $clog2(NUM_PORTS);

    logic [3:0]           cmd_a        [NUM_PORTS];
    logic [DATA_W-1:0]    data_a       [NUM_PORTS];
    logic [TAG_W-1:0]     tag_a        [NUM_PORTS];
    logic [TAG_W-1:0]     add_tag_a    [NUM_PORTS];
    logic [TAG_W-1:0]     shift_tag_a  [NUM_PORTS];
    tag_entry_t           add_entry_a  [NUM_PORTS];
    tag_entry_t           shift_entry_a[NUM_PORTS];
    logic [TAG_W-1:0]     wr_tag_a     [NUM_PORTS];
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] add_ready, shift_ready, shift_req, add_gnt, shift_gnt;
    logic [PORT_W-1:0]    add_ptr, shift_ptr, add_sel, shift_sel;
    logic                 add_fire, shift_fire;
    alu_result_t          add_res, shift_res;
    resp_e                resp_q [NUM_PORTS];
    logic [DATA_W-1:0]    data_q [NUM_PORTS];
    logic [TAG_W-1:0]     tag_q  [NUM_PORTS];
    logic                 scan_unused;

    assign scan_out    = 1'b0;
    assign scan_unused = a_clk ^ b_clk ^ scan_in;

    always_comb begin
        cmd_a[0] = req1_cmd_in;  data_a[0] = req1_data_in;  tag_a[0] = req1_tag_in;
        cmd_a[1] = req2_cmd_in;  data_a[1] = req2_data_in;  tag_a[1] = req2_tag_in;
        cmd_a[2] = req3_cmd_in;  data_a[2] = req3_data_in;  tag_a[2] = req3_tag_in;
        cmd_a[3] = req4_cmd_in;  data_a[3] = req4_data_in;  tag_a[3] = req4_tag_in;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        calc2_port_ctrl u_port (
            .c_clk       (c_clk),
            .reset       (reset),
            .cmd_in      (cmd_a[p]),
            .data_in     (data_a[p]),
            .tag_in      (tag_a[p]),
            .add_grant   (add_gnt[p]),
            .shift_grant (shift_gnt[p]),
            .add_ready   (add_ready[p]),
            .shift_ready (shift_ready[p]),
            .add_tag     (add_tag_a[p]),
            .add_entry   (add_entry_a[p]),
            .shift_tag   (shift_tag_a[p]),
            .shift_entry (shift_entry_a[p]),
            .wr_en       (wr_en[p]),
            .wr_tag      (wr_tag_a[p])
        );
    end

    // First requesting port at or after ptr, wrapping around; returns ptr when idle.
    function automatic logic [PORT_W-1:0] rr_index(input logic [NUM_PORTS-1:0] req,
                                                   input logic [PORT_W-1:0]    ptr);
        logic [PORT_W-1:0] idx;
        logic [PORT_W-1:0] cand;
        idx = ptr;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand = ptr + PORT_W'(k);
            if (req[cand]) idx = cand;
        end
        return idx;
    endfunction

    // The shift arbiter only sees ports the add arbiter left alone, so a port never
    // gets two completions in one cycle.
    always_comb begin
        add_sel    = rr_index(add_ready, add_ptr);
        add_fire   = add_ready[add_sel] && add_entry_a[add_sel].valid;
        add_gnt    = '0;
        if (add_fire) add_gnt[add_sel] = 1'b1;
        shift_req  = shift_ready & ~add_gnt;
        shift_sel  = rr_index(shift_req, shift_ptr);
        shift_fire = shift_req[shift_sel] && shift_entry_a[shift_sel].valid;
        shift_gnt  = '0;
        if (shift_fire) shift_gnt[shift_sel] = 1'b1;
        add_res    = alu_addsub(add_entry_a[add_sel].cmd, add_entry_a[add_sel].op1,
                                add_entry_a[add_sel].op2);
        shift_res  = alu_shift(shift_entry_a[shift_sel].cmd, shift_entry_a[shift_sel].op1,
                               shift_entry_a[shift_sel].op2);
    end

    always_ff @(posedge c_clk) begin
        if (!reset) begin
            add_ptr   <= '0;
            shift_ptr <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p] <= RESP_NONE;
                data_q[p] <= '0;
                tag_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                resp_q[p] <= RESP_NONE;
                data_q[p] <= '0;
                tag_q[p]  <= '0;
            end
            if (add_fire) begin
                resp_q[add_sel] <= add_res.resp;
                data_q[add_sel] <= add_res.data;
                tag_q[add_sel]  <= add_tag_a[add_sel];
                add_ptr         <= add_sel + PORT_W'(1);
            end
            if (shift_fire) begin
                resp_q[shift_sel] <= shift_res.resp;
                data_q[shift_sel] <= shift_res.data;
                tag_q[shift_sel]  <= shift_tag_a[shift_sel];
                shift_ptr         <= shift_sel + PORT_W'(1);
            end
        end
    end

    always_comb begin
        out_resp1 = resp_q[0];  out_data1 = data_q[0];  out_tag1 = tag_q[0];
        out_resp2 = resp_q[1];  out_data2 = data_q[1];  out_tag2 = tag_q[1];
        out_resp3 = resp_q[2];  out_data3 = data_q[2];  out_tag3 = tag_q[2];
        out_resp4 = resp_q[3];  out_data4 = data_q[3];  out_tag4 = tag_q[3];
    end

`ifdef CALC2_SVA_EN
    logic [NUM_TAGS-1:0] sva_out [NUM_PORTS];
    logic [4:0]          sva_age [NUM_PORTS][NUM_TAGS];

    // Outstanding from table write until the response is seen on the outputs.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                sva_out[p] <= '0;
                for (int t = 0; t < NUM_TAGS; t++) sva_age[p][t] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int t = 0; t < NUM_TAGS; t++) begin
                    if (resp_q[p] != RESP_NONE && tag_q[p] == TAG_W'(t)) sva_out[p][t] <= 1'b0;
                    if (wr_en[p] && wr_tag_a[p] == TAG_W'(t)) begin
                        sva_out[p][t] <= 1'b1;
                        sva_age[p][t] <= '0;
                    end else if (sva_out[p][t]) begin
                        sva_age[p][t] <= sva_age[p][t] + 5'd1;
                    end
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_sva
        a_resp_legal: assert property (@(posedge c_clk) disable iff (!reset)
            resp_q[p] != 2'd3);
        a_idle_zero: assert property (@(posedge c_clk) disable iff (!reset)
            (resp_q[p] == RESP_NONE) |-> (data_q[p] == '0 && tag_q[p] == '0));
        a_known_tag: assert property (@(posedge c_clk) disable iff (!reset)
            (resp_q[p] != RESP_NONE) |-> sva_out[p][tag_q[p]]);
        for (genvar t = 0; t < NUM_TAGS; t++) begin : g_tag
            a_latency: assert property (@(posedge c_clk) disable iff (!reset)
                sva_out[p][t] |-> (sva_age[p][t] < 5'd16));
        end
    end
`else
    logic [NUM_PORTS-1:0] wr_unused;
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) wr_unused[p] = wr_en[p] ^ (^wr_tag_a[p]);
    end
`endif
endmodule

// File: tb/tb_calc2_unit.sv
// tb/tb_calc2_unit.sv - directed and randomized self-checking bench for calc2_unit
module tb_calc2_unit;
    localparam logic [3:0] C_ADD = 4'd1;
    localparam logic [3:0] C_SUB = 4'd2;
    localparam logic [3:0] C_SHL = 4'd5;
    localparam logic [3:0] C_SHR = 4'd6;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scan_out;
    logic [3:0]  cmd  [4];
    logic [31:0] data [4];
    logic [1:0]  tag  [4];
    logic [1:0]  resp [4];
    logic [31:0] odata[4];
    logic [1:0]  otag [4];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int epoch    = 0;

    int          issued   [4][4];
    int          answered [4][4];
    int          iss_epoch[4][4];
    int          iss_cyc  [4][4];
    logic [1:0]  m_resp   [4][4];
    logic [31:0] m_data   [4][4];

    calc2_unit dut (
        .c_clk(clk), .reset(resetn), .a_clk(1'b0), .b_clk(1'b0), .scan_in(1'b0), .scan_out(scan_out),
        .req1_cmd_in(cmd[0]), .req1_data_in(data[0]), .req1_tag_in(tag[0]),
        .req2_cmd_in(cmd[1]), .req2_data_in(data[1]), .req2_tag_in(tag[1]),
        .req3_cmd_in(cmd[2]), .req3_data_in(data[2]), .req3_tag_in(tag[2]),
        .req4_cmd_in(cmd[3]), .req4_data_in(data[3]), .req4_tag_in(tag[3]),
        .out_resp1(resp[0]), .out_data1(odata[0]), .out_tag1(otag[0]),
        .out_resp2(resp[1]), .out_data2(odata[1]), .out_tag2(otag[1]),
        .out_resp3(resp[2]), .out_data3(odata[2]), .out_tag3(otag[2]),
        .out_resp4(resp[3]), .out_data4(odata[3]), .out_tag4(otag[3])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference result, packed as {resp, data}.
    function automatic logic [33:0] ref_calc(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            C_ADD:   return (a > 32'hFFFF_FFFF - b) ? {2'd2, 32'd0} : {2'd1, a + b};
            C_SUB:   return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            C_SHL:   return {2'd1, a << (b % 32)};
            C_SHR:   return {2'd1, a >> (b % 32)};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    function automatic bit outstanding(input int p, input int t);
        return (issued[p][t] != answered[p][t]) && (iss_epoch[p][t] == epoch);
    endfunction

    task automatic record(input int p, input logic [3:0] c, input logic [1:0] t,
                          input logic [31:0] a, input logic [31:0] b);
        logic [33:0] r;
        r = ref_calc(c, a, b);
        m_resp[p][t]    = r[33:32];
        m_data[p][t]    = r[31:0];
        issued[p][t]    = issued[p][t] + 1;
        iss_epoch[p][t] = epoch;
        iss_cyc[p][t]   = cyc;
    endtask

    task automatic issue(input int p, input logic [3:0] c, input logic [1:0] t,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        cmd[p] = c; tag[p] = t; data[p] = a;
        record(p, c, t, a, b);
        @(negedge clk);
        cmd[p] = 4'($urandom); tag[p] = 2'($urandom); data[p] = b;
        @(negedge clk);
        cmd[p] = 4'd0; data[p] = $urandom;
    endtask

    task automatic expect_out(input int p, input logic [1:0] r, input logic [31:0] d, input logic [1:0] t);
        check($sformatf("out_resp%0d", p + 1), resp[p], r);
        check($sformatf("out_data%0d", p + 1), odata[p], d);
        check($sformatf("out_tag%0d", p + 1), otag[p], t);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        epoch++;
        for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Scoreboard: every response must match an outstanding tag of its port.
    initial begin
        forever begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                if (resp[p] != 2'd0) begin
                    int t;
                    t = int'(otag[p]);
                    check($sformatf("known_tag_p%0d", p + 1), outstanding(p, t), 1);
                    if (outstanding(p, t)) begin
                        check($sformatf("sb_resp_p%0d_t%0d", p + 1, t), resp[p], m_resp[p][t]);
                        check($sformatf("sb_data_p%0d_t%0d", p + 1, t), odata[p], m_data[p][t]);
                        check($sformatf("latency_p%0d_t%0d", p + 1, t), (cyc - iss_cyc[p][t]) <= 16, 1);
                        answered[p][t] = issued[p][t];
                    end
                end else begin
                    check($sformatf("idle_data_p%0d", p + 1), odata[p], 0);
                    check($sformatf("idle_tag_p%0d", p + 1), otag[p], 0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          phase   [4];
        logic [31:0] pend_op2[4];
        logic [3:0]  cmd_tbl [8];
        cmd_tbl = '{C_ADD, C_ADD, C_SUB, C_SUB, C_SHL, C_SHR, 4'd3, 4'd12};
        for (int p = 0; p < 4; p++) begin
            cmd[p] = 4'd0; data[p] = '0; tag[p] = '0; phase[p] = 1'b0; pend_op2[p] = '0;
            for (int t = 0; t < 4; t++) begin
                issued[p][t] = 0; answered[p][t] = 0; iss_epoch[p][t] = 0; iss_cyc[p][t] = 0;
                m_resp[p][t] = '0; m_data[p][t] = '0;
            end
        end
        repeat (3) @(negedge clk);
        for (int p = 0; p < 4; p++) expect_out(p, 2'd0, 32'd0, 2'd0);
        check("scan_out", scan_out, 0);
        resetn = 1'b1;

        // 1: minimum latency add, one-cycle hold
        issue(0, C_ADD, 2'd0, 32'h1, 32'h2);
        @(negedge clk); expect_out(0, 2'd1, 32'h3, 2'd0);
        @(negedge clk); expect_out(0, 2'd0, 32'h0, 2'd0);

        // 2: add carry, sub underflow, sub equal
        issue(1, C_ADD, 2'd1, 32'hFFFF_FFFF, 32'h1);
        @(negedge clk); expect_out(1, 2'd2, 32'h0, 2'd1);
        issue(1, C_SUB, 2'd2, 32'd5, 32'd6);
        @(negedge clk); expect_out(1, 2'd2, 32'h0, 2'd2);
        issue(1, C_SUB, 2'd3, 32'd6, 32'd6);
        @(negedge clk); expect_out(1, 2'd1, 32'h0, 2'd3);

        // 3: shifts use only the low five bits of operand 2
        issue(2, C_SHL, 2'd0, 32'h1, 32'h21);
        @(negedge clk); expect_out(2, 2'd1, 32'h2, 2'd0);
        issue(2, C_SHR, 2'd1, 32'h8000_0000, 32'd31);
        @(negedge clk); expect_out(2, 2'd1, 32'h1, 2'd1);

        // 4: invalid command
        issue(3, 4'd3, 2'd2, $urandom, $urandom);
        @(negedge clk);
        expect_out(3, 2'd2, 32'h0, 2'd2);
        for (int p = 0; p < 3; p++) check($sformatf("silent_p%0d", p + 1), resp[p], 0);

        // 5: simultaneous adds drain round-robin 1..4, shift overlaps on port 1
        do_reset();
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            cmd[p] = C_ADD; tag[p] = 2'(p); data[p] = 32'(10 * (p + 1));
            record(p, C_ADD, 2'(p), 32'(10 * (p + 1)), 32'(p + 1));
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; data[p] = 32'(p + 1); end
        @(negedge clk);
        cmd[0] = C_SHL; tag[0] = 2'd3; data[0] = 32'd3;
        record(0, C_SHL, 2'd3, 32'd3, 32'd5);
        @(negedge clk); expect_out(0, 2'd1, 32'd11, 2'd0);
        cmd[0] = 4'd0; data[0] = 32'd5;
        @(negedge clk); expect_out(1, 2'd1, 32'd22, 2'd1);
        data[0] = $urandom;
        @(negedge clk); expect_out(2, 2'd1, 32'd33, 2'd2); expect_out(0, 2'd1, 32'h60, 2'd3);
        @(negedge clk); expect_out(3, 2'd1, 32'd44, 2'd3); check("p1_quiet", resp[0], 0);

        // 6: reset while commands sit in the tag tables drops them
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            cmd[p] = C_ADD; tag[p] = 2'(p); data[p] = $urandom_range(1, 100);
            record(p, C_ADD, 2'(p), data[p], 32'd1);
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; data[p] = 32'd1; end
        @(negedge clk);
        resetn = 1'b0;
        epoch++;
        @(negedge clk);
        resetn = 1'b1;
        repeat (4) begin
            for (int p = 0; p < 4; p++) check($sformatf("drop_p%0d", p + 1), resp[p], 0);
            @(negedge clk);
        end
        issue(0, C_ADD, 2'd1, 32'd7, 32'd8);
        @(negedge clk); expect_out(0, 2'd1, 32'd15, 2'd1);

        // Randomized traffic on all ports, checked by the scoreboard
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            for (int p = 0; p < 4; p++) begin
                int free_tags[$];
                free_tags.delete();
                for (int t = 0; t < 4; t++) if (!outstanding(p, t)) free_tags.push_back(t);
                if (phase[p]) begin
                    cmd[p] = 4'($urandom); data[p] = pend_op2[p]; phase[p] = 1'b0;
                end else if ($urandom_range(0, 4) == 0 && free_tags.size() > 0) begin
                    logic [3:0]  c;
                    logic [1:0]  t;
                    logic [31:0] a;
                    logic [31:0] b;
                    c = cmd_tbl[$urandom_range(0, 7)];
                    t = 2'(free_tags[$urandom_range(0, free_tags.size() - 1)]);
                    a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
                    b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                    if (c == C_SUB && $urandom_range(0, 3) == 0) b = a;
                    cmd[p] = c; tag[p] = t; data[p] = a;
                    pend_op2[p] = b; phase[p] = 1'b1;
                    record(p, c, t, a, b);
                end else begin
                    cmd[p] = 4'd0; data[p] = $urandom;
                end
            end
        end
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (phase[p]) data[p] = pend_op2[p];
            cmd[p] = 4'd0;
        end
        repeat (40) @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            int left;
            left = 0;
            for (int t = 0; t < 4; t++) if (outstanding(p, t)) left++;
            check($sformatf("drain_p%0d", p + 1), left, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
